// File: rtl/wb4_fifo_wr_arbiter.sv
// wb4_fifo_wr_arbiter: round-robin arbiter that shares one pipelined
// Wishbone B4 FIFO write port among several producer masters.
module wb4_fifo_wr_arbiter #(
    parameter int P_NUM_REQ   = 4,
    parameter int P_DATA_MSB  = 7,
    parameter int P_BURST_MAX = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [P_NUM_REQ-1:0]                 i_wb4_req_cyc,
    input  logic [P_NUM_REQ-1:0]                 i_wb4_req_stb,
    input  logic [P_NUM_REQ*(P_DATA_MSB+1)-1:0]  i_wb4_req_data,
    output logic [P_NUM_REQ-1:0]                 o_wb4_req_ack,
    output logic [P_NUM_REQ-1:0]                 o_wb4_req_stall,
    output logic                                 o_wb4_fifo_cyc,
    output logic                                 o_wb4_fifo_stb,
    output logic [P_DATA_MSB:0]                  o_wb4_fifo_data,
    input  logic                                 i_wb4_fifo_ack,
    input  logic                                 i_wb4_fifo_stall,
    output logic [P_NUM_REQ-1:0]                 o_grant
);

    localparam int W     = P_DATA_MSB + 1;
    localparam int IDX_W = $clog2(P_NUM_REQ);
    localparam int CNT_W = $clog2(P_BURST_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(P_BURST_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic [IDX_W-1:0] last_ptr;
    logic [IDX_W-1:0] last_ptr_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] outst_nxt;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] scan_idx;

    logic             cyc_g;
    logic             stb_g;
    logic [W-1:0]     data_g;

    logic             cap;
    logic             accepted;
    logic             ack_vld;

    // Round-robin pick: first requester with CYC high after the last owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = 1; i <= P_NUM_REQ; i++) begin
            scan_idx = IDX_W'((int'(last_ptr) + i) % P_NUM_REQ);
            if (!pick_vld && i_wb4_req_cyc[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Select the granted requester's CYC, STB and data.
    always_comb begin
        cyc_g  = 1'b0;
        stb_g  = 1'b0;
        data_g = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                cyc_g  = i_wb4_req_cyc[k];
                stb_g  = i_wb4_req_stb[k];
                data_g = i_wb4_req_data[k*W +: W];
            end
        end
    end

    // Next-state logic and all bus outputs of the tenure FSM.
    always_comb begin
        cap = (beat_cnt == CNT_MAX);
        // An ACK with nothing outstanding is stray and is swallowed.
        ack_vld = i_wb4_fifo_ack && (outst != '0);

        state_nxt    = state;
        gnt_idx_nxt  = gnt_idx;
        last_ptr_nxt = last_ptr;

        o_wb4_fifo_cyc  = 1'b0;
        o_wb4_fifo_stb  = 1'b0;
        o_wb4_fifo_data = '0;
        o_wb4_req_ack   = '0;
        o_wb4_req_stall = '1;
        o_grant         = '0;

        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt   = S_GRANT;
                    gnt_idx_nxt = pick_idx;
                end
            end
            S_GRANT: begin
                o_wb4_fifo_cyc           = 1'b1;
                o_wb4_fifo_stb           = stb_g && !cap;
                o_wb4_fifo_data          = data_g;
                o_wb4_req_stall[gnt_idx] = i_wb4_fifo_stall || cap;
                o_wb4_req_ack[gnt_idx]   = ack_vld && cyc_g;
                o_grant[gnt_idx]         = 1'b1;
                // With cap set STB is forced low, so no beat can land.
                if (!cyc_g || cap) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_wb4_fifo_cyc         = 1'b1;
                o_wb4_req_ack[gnt_idx] = ack_vld && cyc_g;
                o_grant[gnt_idx]       = 1'b1;
                if (outst == '0) begin
                    state_nxt    = S_IDLE;
                    last_ptr_nxt = gnt_idx;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        accepted = o_wb4_fifo_stb && !i_wb4_fifo_stall;
    end

    // Beat and outstanding-ACK counters.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        outst_nxt    = outst;

        if (state == S_IDLE && pick_vld) begin
            beat_cnt_nxt = '0;
        end else if (accepted && !cap) begin
            beat_cnt_nxt = beat_cnt + 1'b1;
        end

        // Accept and ACK in the same cycle cancel out.
        if (accepted && !ack_vld) begin
            if (outst != CNT_MAX) begin
                outst_nxt = outst + 1'b1;
            end
        end else if (!accepted && ack_vld) begin
            outst_nxt = outst - 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            gnt_idx  <= '0;
            last_ptr <= IDX_LAST;
            beat_cnt <= '0;
            outst    <= '0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            last_ptr <= last_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            outst    <= outst_nxt;
        end
    end

endmodule

// File: tb/tb_wb4_fifo_wr_arbiter.sv
// tb_wb4_fifo_wr_arbiter: directed vector table plus hand-written
// sequences for bursts, stalls, draining and reset.
module tb_wb4_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 8;

    localparam logic [31:0] DATA0 = 32'hD3C2B1A0;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_cyc;
    logic [N-1:0]   req_stb;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   req_stall;
    logic           fifo_cyc;
    logic           fifo_stb;
    logic [W-1:0]   fifo_data;
    logic           fifo_ack;
    logic           fifo_stall;
    logic [N-1:0]   grant;

    always #5 clk = ~clk;

    wb4_fifo_wr_arbiter #(
        .P_NUM_REQ  (N),
        .P_DATA_MSB (W - 1),
        .P_BURST_MAX(B)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wb4_req_cyc   (req_cyc),
        .i_wb4_req_stb   (req_stb),
        .i_wb4_req_data  (req_data),
        .o_wb4_req_ack   (req_ack),
        .o_wb4_req_stall (req_stall),
        .o_wb4_fifo_cyc  (fifo_cyc),
        .o_wb4_fifo_stb  (fifo_stb),
        .o_wb4_fifo_data (fifo_data),
        .i_wb4_fifo_ack  (fifo_ack),
        .i_wb4_fifo_stall(fifo_stall),
        .o_grant         (grant)
    );

    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic [31:0] data;
        logic        ack;
        logic        stall;
        logic [3:0]  e_grant;
        logic        e_cyc;
        logic        e_stb;
        logic [7:0]  e_data;
        logic [3:0]  e_ack;
        logic [3:0]  e_stall;
    } vec_t;

    vec_t vecs[9];

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   model_en;
    logic acc_q;
    int   g;
    int   beats;
    bit   capchk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; optional FIFO model ACKs each beat a cycle later.
    task automatic step();
        acc_q = fifo_stb & ~fifo_stall;
        @(negedge clk);
        if (model_en) fifo_ack = acc_q;
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_cyc    = '0;
        req_stb    = '0;
        req_data   = DATA0;
        fifo_ack   = 1'b0;
        fifo_stall = 1'b0;
        model_en   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 40 && grant == '0; n++) step();
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_grant"}, 32'(grant), 32'h0);
        chk({name, "_cyc"}, 32'(fifo_cyc), 32'h0);
        chk({name, "_stb"}, 32'(fifo_stb), 32'h0);
        chk({name, "_data"}, 32'(fifo_data), 32'h0);
        chk({name, "_ack"}, 32'(req_ack), 32'h0);
        chk({name, "_stall"}, 32'(req_stall), 32'hF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'h0, 4'h0, 32'hD3C2B1A0, 0, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'hF};
        vecs[1] = '{4'h1, 4'h1, 32'hD3C2B1A0, 0, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'hF};
        vecs[2] = '{4'h1, 4'h1, 32'hD3C2B1A0, 0, 0, 4'h1, 1, 1, 8'hA0, 4'h0, 4'hE};
        vecs[3] = '{4'h1, 4'h1, 32'hD3C2B1A1, 1, 0, 4'h1, 1, 1, 8'hA1, 4'h1, 4'hE};
        vecs[4] = '{4'h1, 4'h1, 32'hD3C2B1A2, 1, 0, 4'h1, 1, 1, 8'hA2, 4'h1, 4'hE};
        vecs[5] = '{4'h1, 4'h0, 32'hD3C2B1A2, 1, 0, 4'h1, 1, 0, 8'hA2, 4'h1, 4'hE};
        vecs[6] = '{4'h0, 4'h0, 32'hD3C2B1A2, 0, 0, 4'h1, 1, 0, 8'hA2, 4'h0, 4'hE};
        vecs[7] = '{4'h0, 4'h0, 32'hD3C2B1A2, 0, 0, 4'h1, 1, 0, 8'h00, 4'h0, 4'hF};
        vecs[8] = '{4'h0, 4'h0, 32'hD3C2B1A2, 1, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'hF};

        // Reset values.
        do_reset();
        chk_idle("reset");

        // T1: single requester, three beats, vector table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_cyc    = vecs[i].cyc;
            req_stb    = vecs[i].stb;
            req_data   = vecs[i].data;
            fifo_ack   = vecs[i].ack;
            fifo_stall = vecs[i].stall;
            #1;
            chk($sformatf("t1_v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("t1_v%0d_cyc", i), 32'(fifo_cyc), 32'(vecs[i].e_cyc));
            chk($sformatf("t1_v%0d_stb", i), 32'(fifo_stb), 32'(vecs[i].e_stb));
            chk($sformatf("t1_v%0d_data", i), 32'(fifo_data), 32'(vecs[i].e_data));
            chk($sformatf("t1_v%0d_ack", i), 32'(req_ack), 32'(vecs[i].e_ack));
            chk($sformatf("t1_v%0d_stall", i), 32'(req_stall), 32'(vecs[i].e_stall));
        end

        // T2: all requesters busy; order 0,1,2,3,0 and 8 beats each.
        do_reset();
        req_cyc  = 4'hF;
        req_stb  = 4'hF;
        model_en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            g      = t % N;
            beats  = 0;
            capchk = 1'b0;
            wait_grant();
            chk($sformatf("t2_t%0d_grant", t), 32'(grant), 32'(1) << g);
            chk($sformatf("t2_t%0d_data", t), 32'(fifo_data),
                (DATA0 >> (8 * g)) & 32'hFF);
            for (int n = 0; n < 40 && grant != '0; n++) begin
                if (beats == B && !capchk) begin
                    chk($sformatf("t2_t%0d_cap_stall", t), 32'(req_stall), 32'hF);
                    chk($sformatf("t2_t%0d_cap_stb", t), 32'(fifo_stb), 32'h0);
                    capchk = 1'b1;
                end
                if (fifo_stb && !fifo_stall) beats++;
                step();
            end
            chk($sformatf("t2_t%0d_beats", t), 32'(beats), 32'(B));
        end

        // T3: FIFO stalls five cycles in the middle of a req1 burst.
        do_reset();
        req_cyc  = 4'b0010;
        req_stb  = 4'b0010;
        model_en = 1'b1;
        wait_grant();
        chk("t3_grant", 32'(grant), 32'h2);
        beats = 0;
        for (int i = 0; i < 3; i++) begin
            if (fifo_stb && !fifo_stall) beats++;
            step();
        end
        fifo_stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_s%0d_stall", i), 32'(req_stall), 32'hF);
            chk($sformatf("t3_s%0d_data", i), 32'(fifo_data), 32'hB1);
            chk($sformatf("t3_s%0d_grant", i), 32'(grant), 32'h2);
            step();
        end
        fifo_stall = 1'b0;
        #1;
        chk("t3_resume_stall", 32'(req_stall), 32'hD);
        chk("t3_resume_stb", 32'(fifo_stb), 32'h1);
        for (int n = 0; n < 20 && req_stall[1] == 1'b0; n++) begin
            if (fifo_stb) beats++;
            step();
        end
        chk("t3_beats", 32'(beats), 32'(B));
        req_cyc = '0;
        req_stb = '0;
        #1;
        for (int n = 0; n < 10 && grant != '0; n++) step();
        chk("t3_idle", 32'(grant), 32'h0);

        // T4: req2 drops CYC with two beats outstanding.
        do_reset();
        req_cyc = 4'b0100;
        req_stb = 4'b0100;
        #1;
        step();
        chk("t4_grant", 32'(grant), 32'h4);
        step();
        step();
        req_cyc = '0;
        req_stb = '0;
        #1;
        chk("t4_drop_stb", 32'(fifo_stb), 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_d%0d_grant", i), 32'(grant), 32'h4);
            chk($sformatf("t4_d%0d_stall", i), 32'(req_stall), 32'hF);
            chk($sformatf("t4_d%0d_cyc", i), 32'(fifo_cyc), 32'h1);
            step();
        end
        fifo_ack = 1'b1;
        #1;
        chk("t4_ack1_req", 32'(req_ack), 32'h0);
        step();
        chk("t4_ack2_req", 32'(req_ack), 32'h0);
        chk("t4_ack2_grant", 32'(grant), 32'h4);
        step();
        fifo_ack = 1'b0;
        #1;
        chk("t4_last_drain", 32'(grant), 32'h4);
        step();
        chk("t4_idle_grant", 32'(grant), 32'h0);
        chk("t4_idle_cyc", 32'(fifo_cyc), 32'h0);

        // T5: accept and ACK together at outst=1 keeps one outstanding.
        do_reset();
        req_cyc = 4'b0001;
        req_stb = 4'b0001;
        #1;
        step();
        chk("t5_grant", 32'(grant), 32'h1);
        step();
        fifo_ack = 1'b1;
        #1;
        chk("t5_both_ack", 32'(req_ack), 32'h1);
        chk("t5_both_stb", 32'(fifo_stb), 32'h1);
        step();
        fifo_ack = 1'b0;
        req_cyc  = '0;
        req_stb  = '0;
        #1;
        step();
        chk("t5_drain_wait", 32'(grant), 32'h1);
        step();
        chk("t5_drain_hold", 32'(grant), 32'h1);
        fifo_ack = 1'b1;
        #1;
        chk("t5_drop_ack", 32'(req_ack), 32'h0);
        step();
        fifo_ack = 1'b0;
        #1;
        chk("t5_last_drain", 32'(grant), 32'h1);
        step();
        chk("t5_idle", 32'(grant), 32'h0);

        // T6: reset while req3 holds the grant, then req0 wins.
        do_reset();
        req_cyc = 4'b1000;
        req_stb = 4'b1000;
        #1;
        step();
        chk("t6_grant", 32'(grant), 32'h8);
        step();
        rst      = 1'b1;
        req_cyc  = 4'b1001;
        req_stb  = 4'b1001;
        fifo_ack = 1'b1;
        #1;
        chk_idle("t6_rst");
        @(negedge clk);
        rst      = 1'b0;
        fifo_ack = 1'b0;
        #1;
        chk("t6_post_idle", 32'(grant), 32'h0);
        step();
        chk("t6_post_grant", 32'(grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
